uart_tx_arbiter: RTL and testbench



---
 rtl/uart_arb_pkg.sv | 32 +++
 rtl/rr_arbiter.sv | 42 ++++
 rtl/uart_tx_arbiter.sv | 203 ++++++++++++++++++++
 tb/tb_uart_tx_arbiter.sv | 302 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module   : uart_arb_pkg
// Purpose  : Shared types and constants for the UART transmit arbiter:
//            sequencer state encoding, UART register addresses and the
//            baud divisor computation.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package uart_arb_pkg;

  typedef enum logic [1:0] {
    ST_INIT  = 2'd0,
    ST_IDLE  = 2'd1,
    ST_WRITE = 2'd2,
    ST_GAP   = 2'd3
  } arb_state_e;

  // UART slave register map
  localparam logic [31:0] ADR_DATA = 32'd0;
  localparam logic [31:0] ADR_DIV  = 32'd1;
  localparam logic [31:0] ADR_THRU = 32'd2;

  // 16x oversampling divisor, truncated to the 16-bit divisor register
  function automatic logic [15:0] calc_div(input int clk_freq, input int baud);
    int q;
    q = clk_freq / baud / 16;
    return q[15:0];
  endfunction

endpackage
`default_nettype wire

// File: rtl/rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : rr_arbiter
// Purpose  : Combinational N-way round-robin pick. Searches i_req starting at
//            position i_ptr and wrapping; the first set bit wins.
// Ports    : i_req  [N_REQ]   request vector
//            i_ptr  [IDW]     search start position (< N_REQ)
//            o_gnt  [N_REQ]   one-hot grant (all zero when no request)
//            o_idx  [IDW]     index of the granted request
//            o_any            at least one request present
// Revision : 1.0 - initial release
// ============================================================================
module rr_arbiter #(
  parameter int N_REQ = 4,
  parameter int IDW   = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] i_req,
  input  logic [IDW-1:0]   i_ptr,
  output logic [N_REQ-1:0] o_gnt,
  output logic [IDW-1:0]   o_idx,
  output logic             o_any
);

  logic [IDW-1:0] w_pos;

  always_comb begin
    o_gnt = '0;
    o_idx = '0;
    o_any = 1'b0;
    w_pos = '0;
    for (int k = 0; k < N_REQ; k++) begin
      w_pos = IDW'((int'(i_ptr) + k) % N_REQ);
      if (!o_any && i_req[w_pos]) begin
        o_any        = 1'b1;
        o_gnt[w_pos] = 1'b1;
        o_idx        = w_pos;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/uart_tx_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : uart_tx_arbiter
// Purpose  : Bus-master sequencer in front of the UART slave port. Writes the
//            baud divisor after reset, then shares the UART data register
//            between N_REQ byte producers using round-robin arbitration,
//            absorbing TX-FIFO backpressure (ack_i low).
// Ports    : sys_clk, sys_rst (async, active-high)
//            req_valid/req_data/req_last/req_ready : requester byte streams
//            stb_o/we_o/adr_o/dat_o/ack_i          : UART slave bus
//            init_done                              : divisor written (sticky)
//            grant_id                               : last granted requester
// Options  : UART_ARB_LOCK_EN - hold the grant on one requester until it
//            delivers a byte with req_last set (packet lock).
// Revision : 1.0 - initial release
// ============================================================================
module uart_tx_arbiter
  import uart_arb_pkg::*;
#(
  parameter int N_REQ    = 4,
  parameter int CLK_FREQ = 100000000,
  parameter int BAUD     = 115200,
  parameter int DIV      = int'(calc_div(CLK_FREQ, BAUD))
) (
  input  logic                       sys_clk,
  input  logic                       sys_rst,
  input  logic [N_REQ-1:0]           req_valid,
  input  logic [8*N_REQ-1:0]         req_data,
  input  logic [N_REQ-1:0]           req_last,
  output logic [N_REQ-1:0]           req_ready,
  output logic                       stb_o,
  output logic                       we_o,
  output logic [31:0]                adr_o,
  output logic [31:0]                dat_o,
  input  logic                       ack_i,
  output logic                       init_done,
  output logic [$clog2(N_REQ)-1:0]   grant_id
);

  localparam int IDW = $clog2(N_REQ);

  localparam logic [1:0] c_ST_INIT  = 2'(ST_INIT);
  localparam logic [1:0] c_ST_IDLE  = 2'(ST_IDLE);
  localparam logic [1:0] c_ST_WRITE = 2'(ST_WRITE);
  localparam logic [1:0] c_ST_GAP   = 2'(ST_GAP);

  localparam logic [15:0] c_DIV = DIV[15:0];

  logic [1:0]       r_state;
  logic [IDW-1:0]   r_rr_ptr;
  logic [IDW-1:0]   r_grant_id;
  logic             r_stb;
  logic             r_we;
  logic [31:0]      r_adr;
  logic [31:0]      r_dat;
  logic             r_init_done;

  logic [N_REQ-1:0] w_eligible;
  logic [N_REQ-1:0] w_gnt;
  logic [IDW-1:0]   w_win;
  logic             w_any;
  logic             w_idle;
  logic [7:0]       w_win_data;
  logic [IDW-1:0]   w_next_ptr;
  logic             w_advance;

  assign w_idle = (r_state == c_ST_IDLE);

  rr_arbiter #(
    .N_REQ (N_REQ),
    .IDW   (IDW)
  ) u_rr_arbiter (
    .i_req (w_eligible),
    .i_ptr (r_rr_ptr),
    .o_gnt (w_gnt),
    .o_idx (w_win),
    .o_any (w_any)
  );

  // Accept pulse exists only in IDLE, so it is one cycle wide by construction
  assign req_ready = w_idle ? w_gnt : '0;

  always_comb begin
    w_win_data = 8'h00;
    for (int i = 0; i < N_REQ; i++) begin
      if (w_gnt[i]) begin
        w_win_data = req_data[8*i +: 8];
      end
    end
  end

  assign w_next_ptr = (w_win == IDW'(N_REQ - 1)) ? '0 : w_win + 1'b1;

`ifdef UART_ARB_LOCK_EN
  logic           r_lock;
  logic [IDW-1:0] r_lock_id;
  logic           w_win_last;

  always_comb begin
    w_win_last = 1'b0;
    for (int i = 0; i < N_REQ; i++) begin
      if (w_gnt[i]) begin
        w_win_last = req_last[i];
      end
    end
  end

  // While a packet is open only its owner may win
  always_comb begin
    w_eligible = req_valid;
    if (r_lock) begin
      w_eligible            = '0;
      w_eligible[r_lock_id] = req_valid[r_lock_id];
    end
  end

  // The pointer moves on only when a packet closes
  assign w_advance = w_win_last;

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      r_lock    <= 1'b0;
      r_lock_id <= '0;
    end else if (w_idle && w_any) begin
      r_lock    <= ~w_win_last;
      r_lock_id <= w_win;
    end
  end
`else
  logic w_unused_last;
  assign w_unused_last = ^req_last;
  assign w_eligible    = req_valid;
  assign w_advance     = 1'b1;
`endif

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      r_state     <= c_ST_INIT;
      r_rr_ptr    <= '0;
      r_grant_id  <= '0;
      r_stb       <= 1'b0;
      r_we        <= 1'b0;
      r_adr       <= '0;
      r_dat       <= '0;
      r_init_done <= 1'b0;
    end else begin
      case (r_state)
        c_ST_INIT: begin
          if (r_stb && ack_i) begin
            r_stb       <= 1'b0;
            r_we        <= 1'b0;
            r_init_done <= 1'b1;
            r_state     <= c_ST_GAP;
          end else begin
            // Strobe rises on the first clock after reset release
            r_stb <= 1'b1;
            r_we  <= 1'b1;
            r_adr <= ADR_DIV;
            r_dat <= {16'h0000, c_DIV};
          end
        end
        c_ST_IDLE: begin
          if (w_any) begin
            r_stb      <= 1'b1;
            r_we       <= 1'b1;
            r_adr      <= ADR_DATA;
            r_dat      <= {24'h000000, w_win_data};
            r_grant_id <= w_win;
            if (w_advance) begin
              r_rr_ptr <= w_next_ptr;
            end
            r_state    <= c_ST_WRITE;
          end
        end
        c_ST_WRITE: begin
          // Bus registers are left untouched while the slave stalls
          if (ack_i) begin
            r_stb   <= 1'b0;
            r_we    <= 1'b0;
            r_state <= c_ST_GAP;
          end
        end
        c_ST_GAP: begin
          r_state <= c_ST_IDLE;
        end
        default: begin
          r_stb   <= 1'b0;
          r_we    <= 1'b0;
          r_state <= c_ST_INIT;
        end
      endcase
    end
  end

  assign stb_o     = r_stb;
  assign we_o      = r_we;
  assign adr_o     = r_adr;
  assign dat_o     = r_dat;
  assign init_done = r_init_done;
  assign grant_id  = r_grant_id;

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_tx_arbiter
// Purpose  : Directed self-checking bench for uart_tx_arbiter (N_REQ=4,
//            default divisor 54). Expected grant orders follow the
//            UART_ARB_LOCK_EN setting of the build.
// Revision : 1.0 - initial release
// ============================================================================
module tb_uart_tx_arbiter;

  localparam int N = 4;

  logic           sys_clk = 1'b0;
  logic           sys_rst;
  logic [N-1:0]   req_valid;
  logic [8*N-1:0] req_data;
  logic [N-1:0]   req_last;
  logic [N-1:0]   req_ready;
  logic           stb_o;
  logic           we_o;
  logic [31:0]    adr_o;
  logic [31:0]    dat_o;
  logic           ack_i;
  logic           init_done;
  logic [1:0]     grant_id;

  int checks   = 0;
  int failures = 0;

  always #5 sys_clk = ~sys_clk;

  uart_tx_arbiter #(.N_REQ(N)) dut (
    .sys_clk   (sys_clk),
    .sys_rst   (sys_rst),
    .req_valid (req_valid),
    .req_data  (req_data),
    .req_last  (req_last),
    .req_ready (req_ready),
    .stb_o     (stb_o),
    .we_o      (we_o),
    .adr_o     (adr_o),
    .dat_o     (dat_o),
    .ack_i     (ack_i),
    .init_done (init_done),
    .grant_id  (grant_id)
  );

  // Bus monitor: log every accepted write as {we, adr[1:0], dat[15:0]}
  logic [18:0] wr_q[$];
  int          wr_cyc[$];
  int          cyc       = 0;
  int          b2b       = 0;
  int          rd_bad    = 0;
  int          upper_bad = 0;
  logic        prev_acc  = 1'b0;

  always @(posedge sys_clk) begin
    cyc++;
    if (stb_o && prev_acc) b2b++;
    if (stb_o && !we_o) rd_bad++;
    prev_acc = stb_o && ack_i;
    if (stb_o && ack_i) begin
      wr_q.push_back({we_o, adr_o[1:0], dat_o[15:0]});
      wr_cyc.push_back(cyc);
      if (adr_o[31:2] != 30'd0 || dat_o[31:16] != 16'd0) upper_bad++;
    end
  end

  initial begin
    #500000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Requester byte sources
  logic [8:0] src_mem [N][8];
  int         src_len [N];
  int         src_pos [N];
  int         gnt_q[$];
  logic [N-1:0] last_r = '0;

  task automatic present(input int i);
    if (src_pos[i] < src_len[i]) begin
      req_valid[i]       = 1'b1;
      req_data[8*i +: 8] = src_mem[i][src_pos[i]][7:0];
      req_last[i]        = src_mem[i][src_pos[i]][8];
    end else begin
      req_valid[i]       = 1'b0;
      req_data[8*i +: 8] = 8'h00;
      req_last[i]        = 1'b0;
    end
  endtask

  task automatic push(input int i, input logic [7:0] b, input logic l);
    src_mem[i][src_len[i]] = {l, b};
    src_len[i]++;
  endtask

  task automatic clr(input int i);
    src_len[i] = 0;
    src_pos[i] = 0;
    present(i);
  endtask

  // One clock: sample ready mid-cycle, advance accepted sources after the
  // edge, drive the next ack value, return at the following negedge.
  task automatic tick(input logic ack_next);
    logic [N-1:0] r;
    #1;
    r = req_ready;
    if (r != '0) chk("ready_onehot", $countones(r), 1);
    if (last_r != '0) chk("ready_pulse", {28'd0, r}, 32'd0);
    last_r = r;
    @(posedge sys_clk);
    #1;
    for (int i = 0; i < N; i++) begin
      if (r[i] && req_valid[i]) begin
        gnt_q.push_back(i);
        src_pos[i]++;
        present(i);
      end
    end
    ack_i = ack_next;
    @(negedge sys_clk);
  endtask

  int         base;
  int         exp_g5[6];
  logic [7:0] exp_d5[6];
  logic [7:0] b;

  initial begin
    sys_rst   = 1'b1;
    ack_i     = 1'b0;
    req_valid = '0;
    req_data  = '0;
    req_last  = '0;
    for (int i = 0; i < N; i++) begin
      src_len[i] = 0;
      src_pos[i] = 0;
    end

    // ---- reset state; requester 0 already holding a byte during INIT ----
    push(0, 8'h41, 1'b1);
    push(0, 8'h42, 1'b1);
    push(0, 8'h43, 1'b1);
    present(0);
    repeat (3) @(negedge sys_clk);
    chk("rst_stb", {31'd0, stb_o}, 32'd0);
    chk("rst_we", {31'd0, we_o}, 32'd0);
    chk("rst_adr", adr_o, 32'd0);
    chk("rst_dat", dat_o, 32'd0);
    chk("rst_ready", {28'd0, req_ready}, 32'd0);
    chk("rst_init_done", {31'd0, init_done}, 32'd0);
    chk("rst_grant_id", {30'd0, grant_id}, 32'd0);

    sys_rst = 1'b0;
    @(negedge sys_clk);
    chk("init_stb", {31'd0, stb_o}, 32'd1);
    chk("init_we", {31'd0, we_o}, 32'd1);
    chk("init_adr", adr_o, 32'd1);
    chk("init_dat", dat_o, 32'd54);
    chk("init_ready", {28'd0, req_ready}, 32'd0);
    tick(1'b0);
    chk("init_stall_stb", {31'd0, stb_o}, 32'd1);
    chk("init_stall_done", {31'd0, init_done}, 32'd0);
    chk("init_stall_ready", {28'd0, req_ready}, 32'd0);
    tick(1'b1);
    chk("init_ack_stb", {31'd0, stb_o}, 32'd1);
    tick(1'b1);
    chk("gap_init_done", {31'd0, init_done}, 32'd1);
    chk("gap_stb", {31'd0, stb_o}, 32'd0);
    chk("gap_ready", {28'd0, req_ready}, 32'd0);
    chk("first_wr_count", wr_q.size(), 32'd1);
    chk("first_wr_div", {13'd0, wr_q[0]}, {13'd0, 1'b1, 2'b01, 16'd54});
    tick(1'b1);
    chk("idle_ready0", {28'd0, req_ready}, 32'd1);

    // ---- requester 0 streams 0x41,0x42,0x43 with no backpressure ----
    for (int k = 0; k < 40 && wr_q.size() < 4; k++) tick(1'b1);
    chk("t2_count", wr_q.size(), 32'd4);
    chk("t2_wr0", {13'd0, wr_q[1]}, {13'd0, 1'b1, 2'b00, 16'h0041});
    chk("t2_wr1", {13'd0, wr_q[2]}, {13'd0, 1'b1, 2'b00, 16'h0042});
    chk("t2_wr2", {13'd0, wr_q[3]}, {13'd0, 1'b1, 2'b00, 16'h0043});
    chk("t2_space01", wr_cyc[2] - wr_cyc[1], 32'd3);
    chk("t2_space12", wr_cyc[3] - wr_cyc[2], 32'd3);
    chk("t2_grant_id", {30'd0, grant_id}, 32'd0);

    // ---- all four valid; pointer sits at 1 after three grants to 0 ----
    tick(1'b1);
    tick(1'b1);
    gnt_q.delete();
    base = wr_q.size();
    for (int i = 0; i < N; i++) begin
      clr(i);
      for (int j = 0; j < 2; j++) begin
        b = 8'((i + 1) * 16 + j);
        push(i, b, 1'b1);
      end
      present(i);
    end
    for (int k = 0; k < 60 && wr_q.size() < base + 8; k++) tick(1'b1);
    chk("t3_count", wr_q.size() - base, 32'd8);
    for (int k = 0; k < 8; k++) begin
      chk("t3_grant", gnt_q[k], (k + 1) % 4);
      b = 8'((((k + 1) % 4) + 1) * 16 + k / 4);
      chk("t3_data", {13'd0, wr_q[base + k]}, {13'd0, 1'b1, 2'b00, 8'h00, b});
    end
    chk("t3_grant_id", {30'd0, grant_id}, 32'd0);

    // ---- backpressure: 10 cycles of ack_i=0 during a write of 0x55 ----
    clr(2);
    push(2, 8'h55, 1'b1);
    present(2);
    for (int k = 0; k < 10 && !stb_o; k++) tick(1'b0);
    chk("t4_start", {31'd0, stb_o}, 32'd1);
    chk("t4_grant_id", {30'd0, grant_id}, 32'd2);
    base = wr_q.size();
    for (int k = 0; k < 10; k++) begin
      chk("t4_stall_stb", {31'd0, stb_o}, 32'd1);
      chk("t4_stall_dat", dat_o, 32'h55);
      tick(k == 9);
    end
    chk("t4_last_stb", {31'd0, stb_o}, 32'd1);
    chk("t4_last_dat", dat_o, 32'h55);
    chk("t4_last_adr", adr_o, 32'd0);
    tick(1'b1);
    chk("t4_gap_stb", {31'd0, stb_o}, 32'd0);
    chk("t4_wr", {13'd0, wr_q[base]}, {13'd0, 1'b1, 2'b00, 16'h0055});
    chk("t4_count", wr_q.size() - base, 32'd1);

    // ---- packet lock vs. interleave; pointer at 3 so requester 1 wins ----
`ifdef UART_ARB_LOCK_EN
    exp_g5 = '{1, 1, 1, 2, 2, 2};
    exp_d5 = '{8'hA1, 8'hA2, 8'hA3, 8'hB1, 8'hB2, 8'hB3};
`else
    exp_g5 = '{1, 2, 1, 2, 1, 2};
    exp_d5 = '{8'hA1, 8'hB1, 8'hA2, 8'hB2, 8'hA3, 8'hB3};
`endif
    gnt_q.delete();
    base = wr_q.size();
    clr(1);
    clr(2);
    push(1, 8'hA1, 1'b0);
    push(1, 8'hA2, 1'b0);
    push(1, 8'hA3, 1'b1);
    push(2, 8'hB1, 1'b1);
    push(2, 8'hB2, 1'b1);
    push(2, 8'hB3, 1'b1);
    present(1);
    present(2);
    for (int k = 0; k < 60 && wr_q.size() < base + 6; k++) tick(1'b1);
    chk("t5_count", wr_q.size() - base, 32'd6);
    for (int k = 0; k < 6; k++) begin
      chk("t5_grant", gnt_q[k], exp_g5[k]);
      chk("t5_data", {13'd0, wr_q[base + k]}, {13'd0, 1'b1, 2'b00, 8'h00, exp_d5[k]});
    end

    // ---- reset pulsed mid-WRITE with ack_i=0 ----
    clr(0);
    push(0, 8'h77, 1'b1);
    present(0);
    for (int k = 0; k < 10 && !stb_o; k++) tick(1'b0);
    chk("t6_write_dat", dat_o, 32'h77);
    chk("t6_write_stb", {31'd0, stb_o}, 32'd1);
    base = wr_q.size();
    #2;
    sys_rst = 1'b1;
    #1;
    chk("t6_async_stb", {31'd0, stb_o}, 32'd0);
    chk("t6_async_init_done", {31'd0, init_done}, 32'd0);
    chk("t6_async_dat", dat_o, 32'd0);
    @(negedge sys_clk);
    @(negedge sys_clk);
    clr(0);
    ack_i   = 1'b1;
    last_r  = '0;
    sys_rst = 1'b0;
    for (int k = 0; k < 4; k++) tick(1'b1);
    chk("t6_count", wr_q.size() - base, 32'd1);
    chk("t6_div_rewrite", {13'd0, wr_q[base]}, {13'd0, 1'b1, 2'b01, 16'd54});
    chk("t6_init_done", {31'd0, init_done}, 32'd1);

    // ---- bus-rule monitors ----
    chk("no_back_to_back", b2b, 32'd0);
    chk("no_read_strobe", rd_bad, 32'd0);
    chk("upper_bits_zero", upper_bad, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
